sccb_config: RTL and testbench



---
 rtl/sccb_config.sv | 217 +++++++++++++++++++++
 tb/tb_sccb_config.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config.sv
// rtl/sccb_config.sv - SCCB register-table loader for the OV5640 camera path
// Walks a {addr16, data8} table and issues one 3-phase SCCB write per entry.
module sccb_config #(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned SCL_HZ   = 100_000,
  parameter logic [7:0]  DEV_ADDR = 8'h78,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic meg25,
  input  logic rst_n,
  input  logic pulse_send,
  output wire  scl,
  inout  wire  sda,
  output logic initial_done,
  output logic busy,
  output logic ack_err
);

  localparam int unsigned DIV      = CLK_HZ / (4 * SCL_HZ);
  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [31:0] MS_CYC   = 32'(CLK_HZ / 1000);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, START, BYTE, STOP, GAP, DELAY, NEXT, DONE} state_t;

  // Address 0xFFFF marks a delay entry; data is the wait in milliseconds.
  function automatic logic [23:0] table_entry(input logic [7:0] idx);
    case (idx)
      8'd0:    return {16'h3103, 8'h11};
      8'd1:    return {16'h3008, 8'h82};
      8'd2:    return {16'hFFFF, 8'h05};
      8'd3:    return {16'h3008, 8'h42};
      default: return {16'hFFFF, 8'h00};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  qtr_q, qtr_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  idx_q, idx_d;
  logic [23:0] entry_q, entry_d;
  logic [31:0] dly_q, dly_d;
  logic        pulse_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;

  logic        tick, rise, sda_in, scl_rel, sda_rel;
  logic [23:0] entry_now;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_sel;
  logic [31:0] dly_tgt;

  assign tick      = (div_q == DIV_M1);
  assign rise      = pulse_send & ~pulse_q;
  assign sda_in    = sda;
  assign entry_now = table_entry(idx_q);
  assign dly_tgt   = 32'(entry_q[7:0]) * MS_CYC;
  assign bit_sel   = 3'd7 - bit_q[2:0];

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = entry_q[23:16];
      2'd2:    cur_byte = entry_q[15:8];
      default: cur_byte = entry_q[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = 16'd0;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    dly_d   = dly_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ack_d   = ack_q;
    scl_rel = 1'b1;
    sda_rel = 1'b1;
    // Quarter divider only runs while the bus is being timed.
    if (state_q inside {START, BYTE, STOP, GAP}) div_d = tick ? 16'd0 : div_q + 16'd1;
    case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ack_d   = 1'b0;
          idx_d   = 8'd0;
          state_d = NEXT;
        end
      end
      NEXT: begin
        qtr_d   = 3'd0;
        bit_d   = 4'd0;
        byte_d  = 2'd0;
        dly_d   = 32'd0;
        entry_d = entry_now;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (entry_now[23:8] == 16'hFFFF) begin
          state_d = DELAY;
        end else begin
          state_d = START;
        end
      end
      START: begin
        sda_rel = 1'b0;
        scl_rel = (qtr_q == 3'd0);
        if (tick) begin
          if (qtr_q == 3'd1) begin
            qtr_d   = 3'd0;
            state_d = BYTE;
          end else begin
            qtr_d = qtr_q + 3'd1;
          end
        end
      end
      BYTE: begin
        scl_rel = (qtr_q == 3'd1) || (qtr_q == 3'd2);
        sda_rel = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_sel];
        if (tick) begin
          if ((qtr_q == 3'd2) && (bit_q == 4'd8) && sda_in) ack_d = 1'b1;
          if (qtr_q == 3'd3) begin
            qtr_d = 3'd0;
            if (bit_q == 4'd8) begin
              bit_d = 4'd0;
              if (byte_q == 2'd3) state_d = STOP;
              else byte_d = byte_q + 2'd1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            qtr_d = qtr_q + 3'd1;
          end
        end
      end
      STOP: begin
        scl_rel = (qtr_q != 3'd0);
        sda_rel = (qtr_q == 3'd2);
        if (tick) begin
          if (qtr_q == 3'd2) begin
            qtr_d   = 3'd0;
            state_d = GAP;
          end else begin
            qtr_d = qtr_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (qtr_q == 3'd7) begin
            qtr_d   = 3'd0;
            idx_d   = idx_q + 8'd1;
            state_d = NEXT;
          end else begin
            qtr_d = qtr_q + 3'd1;
          end
        end
      end
      DELAY: begin
        if (dly_q + 32'd1 >= dly_tgt) begin
          idx_d   = idx_q + 8'd1;
          state_d = NEXT;
        end else begin
          dly_d = dly_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge meg25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 16'd0;
      qtr_q   <= 3'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      idx_q   <= 8'd0;
      entry_q <= 24'd0;
      dly_q   <= 32'd0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      dly_q   <= dly_d;
      pulse_q <= pulse_send;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // Open-drain: a line is only ever pulled low or released.
  assign scl          = scl_rel ? 1'bz : 1'b0;
  assign sda          = sda_rel ? 1'bz : 1'b0;
  assign initial_done = done_q;
  assign busy         = busy_q;
  assign ack_err      = ack_q;

endmodule

// File: tb/tb_sccb_config.sv
// tb/tb_sccb_config.sv - randomized bench for sccb_config with an SCCB bus decoder model
module tb_sccb_config;

  localparam int CLK_HZ  = 1_200_000;
  localparam int SCL_HZ  = 100_000;
  localparam int DIV     = CLK_HZ / (4 * SCL_HZ);
  localparam int MS_CYC  = CLK_HZ / 1000;
  localparam int TIMEOUT = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_send = 1'b0;
  logic slave_ack = 1'b1;
  logic slave_drive = 1'b0;
  logic initial_done, busy, ack_err;
  wire  scl_w, sda_w;

  pullup (scl_w);
  pullup (sda_w);
  assign sda_w = slave_drive ? 1'b0 : 1'bz;

  sccb_config #(
    .CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR(8'h78), .NUM_REGS(4)
  ) dut (
    .meg25(clk), .rst_n(rst_n), .pulse_send(pulse_send), .scl(scl_w), .sda(sda_w),
    .initial_done(initial_done), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  logic [15:0] t_addr [4] = '{16'h3103, 16'h3008, 16'hFFFF, 16'h3008};
  logic [7:0]  t_data [4] = '{8'h11, 8'h82, 8'h05, 8'h42};

  int tests = 0, fails = 0;
  int cyc = 0, phase = 0, launch_cyc = 0, run_no = 0;
  int bitcnt = 0, last_rise = 0, stop_cyc = 0, stops_in_run = 0;
  int last_idle = 0, exp_done_gap = 0, e_gap = 0, rbit = 0;
  bit in_xfer = 0, have_stop = 0, hi_skip = 0, exp_ack_err = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_pulse = 1'b0;
  logic [7:0] shreg = 8'h00, e_byte;
  logic [7:0] exp_bytes [$];
  logic [7:0] log_bytes [$];
  int exp_idle [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d..%0d", name, cyc, got, lo, hi);
    end
  endtask

  // Expected bus traffic for one run, derived from the table contents.
  task automatic build_run();
    int pend = 0;
    bit first = 1;
    exp_bytes.delete();
    exp_idle.delete();
    log_bytes.delete();
    for (int i = 0; i < 4; i++) begin
      if (t_addr[i] == 16'hFFFF) begin
        pend += int'(t_data[i]) * MS_CYC;
      end else begin
        if (!first) exp_idle.push_back(9 * DIV + pend);
        first = 0;
        pend = 0;
        exp_bytes.push_back(8'h78);
        exp_bytes.push_back(t_addr[i][15:8]);
        exp_bytes.push_back(t_addr[i][7:0]);
        exp_bytes.push_back(t_data[i]);
      end
    end
    exp_done_gap = 9 * DIV + pend;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_scl", scl_w, 1);
      chk("rst_sda", sda_w, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", initial_done, 0);
      chk("rst_ack_err", ack_err, 0);
      phase = 0;
      in_xfer = 0;
      have_stop = 0;
      slave_drive = 1'b0;
    end else begin
      if (pulse_send && !prev_pulse && phase != 1) begin
        phase = 1;
        launch_cyc = cyc;
        have_stop = 0;
        in_xfer = 0;
        stops_in_run = 0;
        exp_ack_err = !slave_ack;
        build_run();
      end
      if (scl_w && prev_scl && prev_sda && !sda_w) begin
        chk("start_outside_xfer", in_xfer, 0);
        chk("start_in_run", phase == 1, 1);
        if (have_stop) begin
          if (exp_idle.size() == 0) chk("extra_gap", 1, 0);
          else begin
            e_gap = exp_idle.pop_front();
            last_idle = cyc - stop_cyc;
            chk_rng("idle_gap", last_idle, e_gap, e_gap + 4);
          end
        end
        in_xfer = 1;
        bitcnt = 0;
        hi_skip = 1;
        slave_drive = 1'b0;
      end else if (scl_w && prev_scl && !prev_sda && sda_w) begin
        chk("stop_bits", bitcnt, 36);
        in_xfer = 0;
        have_stop = 1;
        stop_cyc = cyc;
        stops_in_run++;
      end
      if (scl_w && !prev_scl && in_xfer) begin
        if (bitcnt > 0) chk("bit_period", cyc - last_rise, 4 * DIV);
        if (bitcnt < 36) begin
          if (bitcnt % 9 < 8) begin
            shreg = {shreg[6:0], sda_w};
          end else begin
            log_bytes.push_back(shreg);
            if (exp_bytes.size() == 0) chk("extra_byte", 1, 0);
            else begin
              e_byte = exp_bytes.pop_front();
              chk("byte", shreg, e_byte);
            end
            chk("ack_slot", sda_w, !slave_ack);
          end
          bitcnt++;
        end
        last_rise = cyc;
      end
      if (!scl_w && prev_scl && in_xfer) begin
        if (hi_skip) hi_skip = 0;
        else chk_rng("scl_high", cyc - last_rise, 2 * DIV - 1, 2 * DIV + 1);
        slave_drive = slave_ack && (bitcnt < 36) && (bitcnt % 9 == 8);
      end
      case (phase)
        0: begin
          chk("idle_busy", busy, 0);
          chk("idle_done", initial_done, 0);
          chk("idle_ack_err", ack_err, 0);
        end
        1: begin
          if (cyc - launch_cyc > TIMEOUT) begin
            chk("timeout", 1, 0);
            phase = 0;
          end else if (cyc - launch_cyc >= 2) begin
            if (!(have_stop && !in_xfer && exp_bytes.size() == 0) || (cyc - stop_cyc < exp_done_gap)) begin
              chk("run_busy", busy, 1);
              chk("run_done", initial_done, 0);
              if (!exp_ack_err) chk("run_ack_err", ack_err, 0);
            end else if (cyc - stop_cyc >= exp_done_gap + 4) begin
              chk("end_done", initial_done, 1);
              chk("end_busy", busy, 0);
              chk("end_ack_err", ack_err, exp_ack_err);
              chk("writes_per_run", stops_in_run, 3);
              chk("gaps_left", exp_idle.size(), 0);
              phase = 2;
              run_no++;
              if (run_no == 1) begin
                chk("lit_nbytes", log_bytes.size(), 12);
                chk("lit_b0", log_bytes[0], 8'h78);
                chk("lit_b1", log_bytes[1], 8'h31);
                chk("lit_b2", log_bytes[2], 8'h03);
                chk("lit_b3", log_bytes[3], 8'h11);
                chk("lit_b4", log_bytes[4], 8'h78);
                chk("lit_b7", log_bytes[7], 8'h82);
                chk("lit_b11", log_bytes[11], 8'h42);
                chk_rng("lit_delay_gap", last_idle, 6027, 6031);
                chk("lit_ack_err", ack_err, 0);
              end
            end
          end
        end
        default: begin
          chk("done_busy", busy, 0);
          chk("done_done", initial_done, 1);
          chk("done_ack_err", ack_err, exp_ack_err);
        end
      endcase
    end
    prev_scl = scl_w;
    prev_sda = sda_w;
    prev_pulse = pulse_send;
  end

  task automatic launch(input int hold);
    @(posedge clk);
    #2 pulse_send = 1'b1;
    repeat (hold) @(posedge clk);
    #2 pulse_send = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < TIMEOUT + 100 && phase == 1; i++) @(posedge clk);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    slave_ack = 1'b1;
    launch(5);
    repeat (3000) @(posedge clk);
    launch(3);
    wait_done();
    repeat (20) @(posedge clk);

    slave_ack = 1'b0;
    launch($urandom_range(1, 4));
    wait_done();
    repeat ($urandom_range(5, 40)) @(posedge clk);

    slave_ack = 1'b1;
    rbit = $urandom_range(18, 26);
    launch(1);
    for (int i = 0; i < TIMEOUT && !(stops_in_run == 1 && in_xfer && bitcnt == rbit); i++) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    slave_ack = 1'($urandom_range(0, 1));
    launch($urandom_range(1, 5));
    wait_done();
    repeat (30) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
